fa_resp_checker: RTL

- Synthesizable response checker for the full-adder family (dataflow, behavioural and case-based implementations).
- Samples one applied vector {ci,a,b} together with the s/co outputs of N_DUT adder instances each valid cycle, and compares every instance against a golden full-adder model.
- Tracks coverage of all 8 input combinations, counts mismatching vectors, latches the first failure, and reports pass/fail once coverage is complete.
- Sits at the receiving end of the exhaustive stimulus path, replacing manual inspection of printed truth tables.

---
 rtl/fa_chk_pkg.sv | 14 +
 rtl/fa_golden.sv | 13 +
 rtl/fa_resp_checker.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fa_chk_pkg.sv
// Shared types and constants for the full-adder response checker family.
package fa_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int unsigned     N_VEC   = 8;
    localparam logic [N_VEC-1:0] COV_ALL = 8'hFF;
    localparam int unsigned     VCNT_W  = 4;

endpackage

// File: rtl/fa_golden.sv
// Golden full-adder model: applied {ci,a,b} to expected sum and carry.
module fa_golden (
    input  logic i_ci,
    input  logic i_a,
    input  logic i_b,
    output logic o_exp_s,
    output logic o_exp_co
);

    assign o_exp_s  = i_a ^ i_b ^ i_ci;
    assign o_exp_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

// File: rtl/fa_resp_checker.sv
// Compares N_DUT full-adder instances against the golden model, tracking
// input coverage, error count and the first failing vector.
module fa_resp_checker
    import fa_chk_pkg::*;
#(
    parameter int unsigned N_DUT = 3,
    parameter int unsigned ERR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              vld_i,
    input  logic              ci_i,
    input  logic              a_i,
    input  logic              b_i,
    input  logic [N_DUT-1:0]  s_i,
    input  logic [N_DUT-1:0]  co_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [VCNT_W-1:0] vec_cnt_o,
    output logic [N_VEC-1:0]  cov_o,
    output logic              fail_vld_o,
    output logic [2:0]        fail_vec_o,
    output logic [N_DUT-1:0]  fail_dut_o
);

    chk_state_e         r_state,    w_state_nxt;
    logic [N_VEC-1:0]   r_cov,      w_cov_nxt;
    logic [ERR_W-1:0]   r_err,      w_err_nxt;
    logic [VCNT_W-1:0]  r_vcnt,     w_vcnt_nxt;
    logic               r_fail_vld, w_fail_vld_nxt;
    logic [2:0]         r_fail_vec, w_fail_vec_nxt;
    logic [N_DUT-1:0]   r_fail_dut, w_fail_dut_nxt;
    logic               r_pass,     w_pass_nxt;

    logic               w_exp_s;
    logic               w_exp_co;
    logic [2:0]         w_vec;
    logic [N_DUT-1:0]   w_mm;

    fa_golden u_golden (
        .i_ci     (ci_i),
        .i_a      (a_i),
        .i_b      (b_i),
        .o_exp_s  (w_exp_s),
        .o_exp_co (w_exp_co)
    );

    assign w_vec = {ci_i, a_i, b_i};
    assign w_mm  = (s_i ^ {N_DUT{w_exp_s}}) | (co_i ^ {N_DUT{w_exp_co}});

    always_comb begin
        w_state_nxt    = r_state;
        w_cov_nxt      = r_cov;
        w_err_nxt      = r_err;
        w_vcnt_nxt     = r_vcnt;
        w_fail_vld_nxt = r_fail_vld;
        w_fail_vec_nxt = r_fail_vec;
        w_fail_dut_nxt = r_fail_dut;
        w_pass_nxt     = r_pass;

        if (start) begin
            // A vector presented alongside start is dropped on purpose.
            w_state_nxt    = RUN;
            w_cov_nxt      = '0;
            w_err_nxt      = '0;
            w_vcnt_nxt     = '0;
            w_fail_vld_nxt = 1'b0;
            w_fail_vec_nxt = '0;
            w_fail_dut_nxt = '0;
            w_pass_nxt     = 1'b0;
        end else if (r_state == RUN) begin
            if (vld_i) begin
                w_cov_nxt[w_vec] = 1'b1;
                if (r_vcnt != '1) begin
                    w_vcnt_nxt = r_vcnt + VCNT_W'(1);
                end
                if (|w_mm) begin
                    if (r_err != '1) begin
                        w_err_nxt = r_err + ERR_W'(1);
                    end
                    if (!r_fail_vld) begin
                        w_fail_vld_nxt = 1'b1;
                        w_fail_vec_nxt = w_vec;
                        w_fail_dut_nxt = w_mm;
                    end
                end
            end
            // Completion is seen one edge after the covering sample lands.
            if (r_cov == COV_ALL) begin
                w_state_nxt = DONE;
                w_pass_nxt  = (w_err_nxt == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cov      <= '0;
            r_err      <= '0;
            r_vcnt     <= '0;
            r_fail_vld <= 1'b0;
            r_fail_vec <= '0;
            r_fail_dut <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cov      <= w_cov_nxt;
            r_err      <= w_err_nxt;
            r_vcnt     <= w_vcnt_nxt;
            r_fail_vld <= w_fail_vld_nxt;
            r_fail_vec <= w_fail_vec_nxt;
            r_fail_dut <= w_fail_dut_nxt;
            r_pass     <= w_pass_nxt;
        end
    end

    assign busy_o     = (r_state == RUN);
    assign done_o     = (r_state == DONE);
    assign pass_o     = r_pass;
    assign err_cnt_o  = r_err;
    assign vec_cnt_o  = r_vcnt;
    assign cov_o      = r_cov;
    assign fail_vld_o = r_fail_vld;
    assign fail_vec_o = r_fail_vec;
    assign fail_dut_o = r_fail_dut;

endmodule
